// File: rtl/dnn_input_loader.sv
// Serial-to-parallel frame loader for the 4-4-2 DNN: 28 words in (x0..x3, then 24 weights), held on parallel buses while ARMED.
// Latency: in_ready rises the cycle after the last word; release takes one RELEASE cycle. Optional WEIGHT_PERSIST_EN: after one full frame, later frames carry only x0..x3.
// Backpressure: s_ready decodes registered state only (high in LOAD); frames are held until top reports both neurons done.
module dnn_input_loader #(
    parameter int WIDTH    = 5,
    parameter int MIN_HOLD = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic             s_ready,
    output logic [WIDTH-1:0] x0,
    output logic [WIDTH-1:0] x1,
    output logic [WIDTH-1:0] x2,
    output logic [WIDTH-1:0] x3,
    output logic [WIDTH-1:0] w04,
    output logic [WIDTH-1:0] w14,
    output logic [WIDTH-1:0] w24,
    output logic [WIDTH-1:0] w34,
    output logic [WIDTH-1:0] w05,
    output logic [WIDTH-1:0] w15,
    output logic [WIDTH-1:0] w25,
    output logic [WIDTH-1:0] w35,
    output logic [WIDTH-1:0] w06,
    output logic [WIDTH-1:0] w16,
    output logic [WIDTH-1:0] w26,
    output logic [WIDTH-1:0] w36,
    output logic [WIDTH-1:0] w07,
    output logic [WIDTH-1:0] w17,
    output logic [WIDTH-1:0] w27,
    output logic [WIDTH-1:0] w37,
    output logic [WIDTH-1:0] w48,
    output logic [WIDTH-1:0] w58,
    output logic [WIDTH-1:0] w68,
    output logic [WIDTH-1:0] w78,
    output logic [WIDTH-1:0] w49,
    output logic [WIDTH-1:0] w59,
    output logic [WIDTH-1:0] w69,
    output logic [WIDTH-1:0] w79,
    output logic             in_ready,
    input  logic             out10_ready,
    input  logic             out11_ready,
    output logic             frame_err
);

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        ARMED   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam int         NWORDS     = 28;
    localparam int         HW         = (MIN_HOLD < 1) ? 1 : $clog2(MIN_HOLD + 1);
    localparam logic [4:0] LAST_FULL  = 5'd27;
    localparam logic [4:0] LAST_SHORT = 5'd3;

    state_t           state;
    state_t           state_nxt;
    logic [4:0]       idx;
    logic [HW-1:0]    hold_cnt;
    logic [WIDTH-1:0] word_q [NWORDS];
    logic             persisted;
    logic [4:0]       end_idx;
    logic             accept;
    logic             at_end;
    logic             good_end;
    logic             bad_end;
    logic             hold_sat;
    logic             done_both;

    assign accept    = s_valid && (state == LOAD);
    assign end_idx   = persisted ? LAST_SHORT : LAST_FULL;
    assign at_end    = (idx == end_idx);
    assign good_end  = accept && at_end && s_last;
    // A frame is malformed when s_last and the terminal index disagree.
    assign bad_end   = accept && (at_end != s_last);
    assign hold_sat  = (hold_cnt == HW'(MIN_HOLD));
    assign done_both = out10_ready && out11_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        in_ready  = 1'b0;
        case (state)
            LOAD: begin
                s_ready = 1'b1;
                if (good_end) begin
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                in_ready = 1'b1;
                // Done flags before saturation are stale leftovers from the prior frame.
                if (hold_sat && done_both) begin
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                state_nxt = LOAD;
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (accept) begin
            if (at_end || s_last) begin
                idx <= '0;
            end else begin
                idx <= idx + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (state != ARMED) begin
            hold_cnt <= '0;
        end else if (!hold_sat) begin
            hold_cnt <= hold_cnt + HW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NWORDS; i++) begin
                word_q[i] <= '0;
            end
        end else if (accept) begin
            word_q[idx] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= bad_end;
        end
    end

`ifdef WEIGHT_PERSIST_EN
    // Once a full frame has armed, later frames only refresh the features.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            persisted <= 1'b0;
        end else if (good_end) begin
            persisted <= 1'b1;
        end
    end
`else
    assign persisted = 1'b0;
`endif

    assign x0  = word_q[0];
    assign x1  = word_q[1];
    assign x2  = word_q[2];
    assign x3  = word_q[3];
    assign w04 = word_q[4];
    assign w14 = word_q[5];
    assign w24 = word_q[6];
    assign w34 = word_q[7];
    assign w05 = word_q[8];
    assign w15 = word_q[9];
    assign w25 = word_q[10];
    assign w35 = word_q[11];
    assign w06 = word_q[12];
    assign w16 = word_q[13];
    assign w26 = word_q[14];
    assign w36 = word_q[15];
    assign w07 = word_q[16];
    assign w17 = word_q[17];
    assign w27 = word_q[18];
    assign w37 = word_q[19];
    assign w48 = word_q[20];
    assign w58 = word_q[21];
    assign w68 = word_q[22];
    assign w78 = word_q[23];
    assign w49 = word_q[24];
    assign w59 = word_q[25];
    assign w69 = word_q[26];
    assign w79 = word_q[27];

endmodule
